// File: rtl/seq_frame_controller.sv
// Serial frame controller: hunts a programmable sync pattern, captures the
// following DATA_W bits and offers them on a valid/ready port with drop counting.
//
// state   | meaning
// IDLE    | stopped; window and bit counter held at 0, pattern loadable
// HUNT    | shifting D through the window looking for the sync pattern
// CAPTURE | shifting DATA_W payload bits into the payload register
module seq_frame_controller #(
  parameter int                PAT_W   = 4,
  parameter logic [PAT_W-1:0]  PAT_RST = 4'b1010,
  parameter int                DATA_W  = 8,
  parameter int                CNT_W   = 8
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              En,
  input  logic              D,
  input  logic [PAT_W-1:0]  Cfg_pat,
  input  logic              Cfg_load,
  output logic              Match,
  output logic [DATA_W-1:0] Frame_data,
  output logic              Frame_valid,
  input  logic              Frame_ready,
  output logic [CNT_W-1:0]  Drop_cnt,
  output logic [1:0]        State
);

  localparam logic [1:0] IDLE    = 2'b00;
  localparam logic [1:0] HUNT    = 2'b01;
  localparam logic [1:0] CAPTURE = 2'b10;

  localparam int               BIT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  logic [1:0]        state;
  logic [PAT_W-1:0]  pat;
  logic [PAT_W-1:0]  window;
  logic [PAT_W-1:0]  window_next;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] sreg;
  logic [DATA_W-1:0] word;
  logic              frame_done;
  logic              transfer;

  // Shift-by-one forms stay legal for the minimum widths (PAT_W=2, DATA_W=1).
  assign window_next = (window << 1) | PAT_W'(D);
  assign word        = (sreg << 1) | DATA_W'(D);

  assign Match      = (state == HUNT) && (window_next == pat);
  assign frame_done = (state == CAPTURE) && En && (bit_cnt == LAST_BIT);
  assign transfer   = Frame_valid && Frame_ready;
  assign State      = state;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state   <= IDLE;
      pat     <= PAT_RST;
      window  <= '0;
      bit_cnt <= '0;
      sreg    <= '0;
    end else begin
      case (state)
        IDLE: begin
          window  <= '0;
          bit_cnt <= '0;
          if (Cfg_load) pat <= Cfg_pat;
          if (En) state <= HUNT;
        end
        HUNT: begin
          if (!En) begin
            state  <= IDLE;
            window <= '0;
          end else if (Match) begin
            // Non-overlapping: the sync bits never seed the next hunt.
            state   <= CAPTURE;
            window  <= '0;
            bit_cnt <= '0;
          end else begin
            window <= window_next;
          end
        end
        CAPTURE: begin
          if (!En) begin
            state   <= IDLE;
            window  <= '0;
            bit_cnt <= '0;
          end else begin
            sreg    <= word;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
              state   <= HUNT;
              window  <= '0;
              bit_cnt <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      Frame_data  <= '0;
      Frame_valid <= 1'b0;
      Drop_cnt    <= '0;
    end else if (frame_done && (!Frame_valid || transfer)) begin
      Frame_data  <= word;
      Frame_valid <= 1'b1;
    end else begin
      // A completed frame here means the held word is still unread: drop it.
      if (frame_done && (Drop_cnt != {CNT_W{1'b1}})) Drop_cnt <= Drop_cnt + 1'b1;
      if (transfer) Frame_valid <= 1'b0;
    end
  end

endmodule
